// File: rtl/if_stage_redirect.sv
// Fetch-stage PC/redirect unit: owns the PC, issues instruction fetches, fills IF/ID,
// and squashes/drains wrong-path fetches when ID resolves a taken branch.
module if_stage_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [1:0]  dbg_state
);
    // Memory handshake: a fetch completes in any cycle where imem_req=1 and imem_ready=1
    // (ready may already be high in the request cycle); imem_addr is held until then.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        accept;
    logic [31:0] pc_inc;

    assign accept = branch_taken & ~freeze;
    assign pc_inc = pc_q + STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            tgt_q        <= 32'h0;
            buf_pc_q     <= 32'h0;
            buf_instr_q  <= 32'h0;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= 32'h0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            buf_pc_q     <= buf_pc_d;
            buf_instr_q  <= buf_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // A bubble keeps the last if_id_pc; only instr/valid are forced to NOP/0.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        buf_pc_d     = buf_pc_q;
        buf_instr_d  = buf_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        case (state_q)
            FETCH: begin
                if (accept) begin
                    ifid_instr_d = 32'h0;
                    ifid_valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d = br_target;
                    end else begin
                        tgt_d   = br_target;
                        state_d = DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_inc;
                    if (!freeze) begin
                        ifid_pc_d    = pc_inc;
                        ifid_instr_d = imem_rdata;
                        ifid_valid_d = 1'b1;
                    end else begin
                        buf_pc_d    = pc_inc;
                        buf_instr_d = imem_rdata;
                        state_d     = HOLD;
                    end
                end else if (!freeze) begin
                    ifid_instr_d = 32'h0;
                    ifid_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (accept) begin
                    pc_d         = br_target;
                    ifid_instr_d = 32'h0;
                    ifid_valid_d = 1'b0;
                    state_d      = FETCH;
                end else if (!freeze) begin
                    ifid_pc_d    = buf_pc_q;
                    ifid_instr_d = buf_instr_q;
                    ifid_valid_d = 1'b1;
                    state_d      = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ready) begin
                    pc_d    = tgt_q;
                    state_d = FETCH;
                end
                if (!freeze) begin
                    ifid_instr_d = 32'h0;
                    ifid_valid_d = 1'b0;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign imem_req    = (state_q != HOLD);
    assign imem_addr   = pc_q;
    assign if_id_pc    = ifid_pc_q;
    assign if_id_instr = ifid_instr_q;
    assign if_id_valid = ifid_valid_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_if_stage_redirect.sv
// Bench for if_stage_redirect: scenario tasks push expected IF/ID captures into a queue,
// a negedge monitor pops them whenever IF/ID is written with a valid instruction.
module tb_if_stage_redirect;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic        frz_at_edge = 1'b0;

    if_stage_redirect #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .br_target(br_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr), .if_id_valid(if_id_valid), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a + 32'h0001_3000 + {16'h0, $urandom_range(0, 0) == 0 ? 16'h0 : 16'h0};
    endfunction

    always @(posedge clk) frz_at_edge <= freeze;

    // Every un-frozen edge rewrites IF/ID, so a valid value then is a new instruction.
    always @(negedge clk) begin
        logic [63:0] exp;
        if (!rst && !frz_at_edge && if_id_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ifid_unexpected: got pc=%h instr=%h valid=1, expected bubble", if_id_pc, if_id_instr);
            end else begin
                exp = exp_q.pop_front();
                if ({if_id_pc, if_id_instr} !== exp) begin
                    errors++;
                    $display("FAIL ifid_capture: got pc=%h instr=%h, expected pc=%h instr=%h",
                             if_id_pc, if_id_instr, exp[63:32], exp[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic frz, input logic bt, input logic [31:0] tgt);
        imem_ready   = rdy;
        imem_rdata   = rdy ? instr_of(imem_addr) : 32'h0;
        freeze       = frz;
        branch_taken = bt;
        br_target    = tgt;
    endtask

    task automatic fetch_seq(input logic [31:0] addr);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== addr) begin
            errors++;
            $display("FAIL fetch_addr: got req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, addr);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        exp_q.push_back({addr + 32'd4, instr_of(addr)});
        tick();
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || if_id_instr !== 32'h0 || dbg_state !== S_FETCH) begin
            errors++;
            $display("FAIL reset_state: got valid=%b pc=%h instr=%h st=%0d, expected 0/0/0/0",
                     if_id_valid, if_id_pc, if_id_instr, dbg_state);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_first_req: got req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) fetch_seq(32'(i * 4));
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL seq_bubble: got valid=%b instr=%h addr=%h, expected 0/0/00000010", if_id_valid, if_id_instr, imem_addr);
        end
    endtask

    task automatic test_branch();
        do_reset();
        fetch_seq(32'h0);
        fetch_seq(32'h4);
        drive(1'b1, 1'b0, 1'b1, 32'h40);
        tick();
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL branch_redirect: got valid=%b instr=%h addr=%h, expected 0/0/00000040", if_id_valid, if_id_instr, imem_addr);
        end
        fetch_seq(32'h40);
        checks++;
        if (if_id_pc !== 32'h44 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL branch_target_pc: got pc=%h valid=%b, expected 00000044/1", if_id_pc, if_id_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i < 4; i++) fetch_seq(32'(i * 4));
        drive(1'b0, 1'b0, 1'b1, 32'h80);
        tick();
        checks++;
        if (dbg_state !== S_DRAIN || imem_req !== 1'b1 || imem_addr !== 32'h10 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_enter: got st=%0d req=%b addr=%h valid=%b, expected 2/1/00000010/0",
                     dbg_state, imem_req, imem_addr, if_id_valid);
        end
        drive(1'b0, 1'b0, 1'b1, 32'h200);
        tick();
        checks++;
        if (dbg_state !== S_DRAIN || imem_addr !== 32'h10 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_ignore_branch: got st=%0d addr=%h valid=%b, expected 2/00000010/0", dbg_state, imem_addr, if_id_valid);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checks++;
        if (dbg_state !== S_FETCH || imem_addr !== 32'h80 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_exit: got st=%0d addr=%h valid=%b, expected 0/00000080/0", dbg_state, imem_addr, if_id_valid);
        end
        fetch_seq(32'h80);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_freeze_hold();
        do_reset();
        fetch_seq(32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        imem_rdata = 32'hDEAD_BEEF;
        exp_q.push_back({32'h8, 32'hDEAD_BEEF});
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (dbg_state !== S_HOLD || imem_req !== 1'b0 || if_id_pc !== 32'h4 || if_id_instr !== instr_of(32'h0) || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_frozen: got st=%0d req=%b pc=%h instr=%h valid=%b, expected 1/0/00000004/%h/1",
                         dbg_state, imem_req, if_id_pc, if_id_instr, if_id_valid, instr_of(32'h0));
            end
            drive(1'b0, 1'b1, 1'b0, 32'h0);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++;
        if (if_id_instr !== 32'hDEAD_BEEF || if_id_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL hold_release: got instr=%h valid=%b req=%b addr=%h, expected deadbeef/1/1/00000008",
                     if_id_instr, if_id_valid, imem_req, imem_addr);
        end
        fetch_seq(32'h8);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_hold_branch();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h60);
        tick();
        checks++;
        if (if_id_valid !== 1'b0 || dbg_state !== S_FETCH || imem_addr !== 32'h60) begin
            errors++;
            $display("FAIL hold_branch: got valid=%b st=%0d addr=%h, expected 0/0/00000060", if_id_valid, dbg_state, imem_addr);
        end
        fetch_seq(32'h60);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_freeze_branch();
        do_reset();
        fetch_seq(32'h0);
        drive(1'b0, 1'b1, 1'b1, 32'h300);
        tick();
        checks++;
        if (imem_addr !== 32'h4 || if_id_pc !== 32'h4 || if_id_valid !== 1'b1 || dbg_state !== S_FETCH) begin
            errors++;
            $display("FAIL freeze_branch: got addr=%h pc=%h valid=%b st=%0d, expected 00000004/00000004/1/0",
                     imem_addr, if_id_pc, if_id_valid, dbg_state);
        end
        fetch_seq(32'h4);
        checks++;
        if (imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL freeze_branch_resume: got addr=%h, expected 00000008", imem_addr);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        fetch_seq(32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h500);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++;
        if (dbg_state !== S_DRAIN || imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL mid_drain_setup: got st=%0d addr=%h, expected 2/00000004", dbg_state, imem_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (if_id_pc !== 32'h0 || if_id_instr !== 32'h0 || if_id_valid !== 1'b0 || imem_addr !== RESET_PC || dbg_state !== S_FETCH) begin
            errors++;
            $display("FAIL async_reset: got pc=%h instr=%h valid=%b addr=%h st=%0d, expected 0/0/0/%h/0",
                     if_id_pc, if_id_instr, if_id_valid, imem_addr, RESET_PC, dbg_state);
        end
        tick();
        rst = 1'b0;
        fetch_seq(RESET_PC);
        checks++;
        if (imem_addr !== RESET_PC + 32'd4) begin
            errors++;
            $display("FAIL post_reset_seq: got addr=%h, expected %h", imem_addr, RESET_PC + 32'd4);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        tick();
        fetch_seq(32'hFFFF_FFF8);
        fetch_seq(32'hFFFF_FFFC);
        checks++;
        if (imem_addr !== 32'h0 || if_id_pc !== 32'h0 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL pc_wrap: got addr=%h pc=%h valid=%b, expected 0/0/1", imem_addr, if_id_pc, if_id_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        n = $urandom_range(5, 10);
        for (int i = 0; i < n; i++) fetch_seq(32'(i * 4));
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_drain();
        test_freeze_hold();
        test_hold_branch();
        test_freeze_branch();
        test_reset_mid_drain();
        test_wrap();
        test_back_to_back();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
